led_out_port: RTL



---
 rtl/led_port_pkg.sv | 40 ++++
 rtl/led_out_port_blink_timer.sv | 50 +++++
 rtl/led_out_port.sv | 107 ++++++++++
 3 files changed

// File: rtl/led_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_port_pkg
// Description : Register offsets, CTRL bit layout and byte-merge helper for
//               the LED output port. Honours optional macro LED_PWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package led_port_pkg;

    localparam logic [31:0] OFF_DATA = 32'd0;
    localparam logic [31:0] OFF_CTRL = 32'd4;

    localparam int BLINK_EN_BIT = 0;
    localparam int INVERT_BIT   = 1;
    localparam int DUTY_LSB     = 8;
    localparam int DUTY_MSB     = 11;

`ifdef LED_PWM_EN
    localparam logic [31:0] CTRL_WMASK = 32'h0000_0F03;
    localparam logic [31:0] CTRL_RESET = 32'h0000_0F00;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_0003;
    localparam logic [31:0] CTRL_RESET = 32'h0000_0000;
`endif

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_out_port_blink_timer.sv
`default_nettype none
// ============================================================================
// Module      : blink_timer
// Description : Prescaler that toggles phase every BLINK_DIV cycles while en
//               is high; counter and phase are held at 0 while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase
);

    localparam int              CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/led_out_port.sv
`default_nettype none
// ============================================================================
// Module      : led_out_port
// Description : Memory-mapped DATA/CTRL output port driving the LED display
//               word, with blink and invert. Optional macro LED_PWM_EN adds
//               a 4-bit brightness duty field in CTRL[11:8].
// Revision    : 1.0 - initial release
// ============================================================================
module led_out_port
    import led_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FC00,
    parameter int          BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic [31:0] led_data
);

    localparam logic [31:0] DATA_ADDR = BASE_ADDR + OFF_DATA;
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + OFF_CTRL;

    logic [31:0] data_q, data_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic [31:0] led_q, led_d;
    logic        hit_data, hit_ctrl;
    logic        phase;
    logic        w_unused_addr;

`ifdef LED_PWM_EN
    logic [3:0]  pwm_q, pwm_d;
`endif

    assign w_unused_addr = ^addr[1:0];

    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_q[BLINK_EN_BIT]),
        .phase (phase)
    );

    always_comb begin
        hit_data = (addr[31:2] == DATA_ADDR[31:2]);
        hit_ctrl = (addr[31:2] == CTRL_ADDR[31:2]);

        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (we && hit_data) data_d = byte_merge(data_q, wdata, be);
        if (we && hit_ctrl) ctrl_d = byte_merge(ctrl_q, wdata, be) & CTRL_WMASK;

        ack_d   = (we || re) && (hit_data || hit_ctrl);

        // A combined we+re is a write, so it returns no read data.
        rdata_d = '0;
        if (re && !we) begin
            if (hit_data)      rdata_d = data_q;
            else if (hit_ctrl) rdata_d = ctrl_q;
        end

        led_d = data_q ^ {32{ctrl_q[INVERT_BIT]}};
        if (ctrl_q[BLINK_EN_BIT] && phase) led_d = '0;
`ifdef LED_PWM_EN
        pwm_d = pwm_q + 4'd1;
        if (pwm_q >= ctrl_q[DUTY_MSB:DUTY_LSB]) led_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ctrl_q  <= CTRL_RESET;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            led_q   <= '0;
`ifdef LED_PWM_EN
            pwm_q   <= '0;
`endif
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            led_q   <= led_d;
`ifdef LED_PWM_EN
            pwm_q   <= pwm_d;
`endif
        end
    end

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign led_data = led_q;

endmodule
`default_nettype wire
